// File: rtl/fetch_pkg.sv
// Shared state encoding, constants and RV32I field positions for the fetch path.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: pointers carry a wrap bit so full and empty are distinct;
// flush is synchronous and overrides push/pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Push into a full buffer only happens alongside a pop, so the slot being
    // overwritten is the head that leaves this cycle.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q[PW-1:0]] <= wdata;
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, issues one outstanding imem request at a time,
// buffers responses for decode and discards the stale response after a redirect.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            fetch_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = XLEN + 32;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW:0]     count;
    logic [PW+1:0]   occ, occ_after;
    logic            space, space_after, push, pop;
    logic [EW-1:0]   fifo_rdata, head;

    assign pop = instr_valid && instr_ready && !redirect_valid;

    // An outstanding request reserves a slot so a later push cannot overflow.
    assign occ         = {1'b0, count} + {{(PW+1){1'b0}}, state_q == ST_WAIT};
    assign space       = occ < (PW+2)'(FIFO_DEPTH);
    assign occ_after   = {1'b0, count} + (PW+2)'(1) - {{(PW+1){1'b0}}, pop};
    assign space_after = occ_after < (PW+2)'(FIFO_DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: if (space) state_d = ST_REQ;
            ST_REQ: begin
                if (imem_req_ready) begin
                    state_d    = ST_WAIT;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    push    = 1'b1;
                    state_d = space_after ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: if (imem_rsp_valid) state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase

        // A response owed at the edge (accepted now or still pending) must be
        // swallowed in DROP; one arriving this cycle is discarded right here.
        if (redirect_valid) begin
            push       = 1'b0;
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            state_d    = ST_REQ;
            if ((state_q == ST_REQ && imem_req_ready) ||
                ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_rsp_valid))
                state_d = ST_DROP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata ({fetch_pc_q - XLEN'(4), imem_rsp_data}),
        .rdata (fifo_rdata),
        .count (count)
    );

    assign instr_valid    = (count != '0);
    assign head           = instr_valid ? fifo_rdata : {RESET_PC, NOP_INSTR};
    assign instr_pc       = head[EW-1:32];
    assign instr_data     = head[31:0];
    assign op             = instr_data[OP_MSB:OP_LSB];
    assign funct3         = instr_data[F3_MSB:F3_LSB];
    assign funct7         = instr_data[F7_MSB:F7_LSB];

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = fetch_pc_q;
    assign fetch_busy     = (state_q != ST_IDLE);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the instruction path: owns the PC, fetches 32-bit RV32I words from instruction memory over a valid/ready request and a valid-only response, and buffers them.
- Presents buffered words to decode with a valid/ready handshake, including pre-sliced op/funct3/funct7 fields that feed the control unit directly.
- Handles branch/jump redirects by flushing the buffer and discarding any in-flight response.

Parameters:
- XLEN, 32, address and PC width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid; never earlier than the cycle after the request handshake.
- imem_rsp_data  in  32  fetched instruction word.
- redirect_valid  in  1  branch/jump taken; one-cycle pulse.
- redirect_pc  in  XLEN  new fetch target.
- instr_valid  out  1  buffer head valid.
- instr_ready  in  1  decode consumes head.
- instr_data  out  32  head instruction word.
- instr_pc  out  XLEN  PC of head instruction.
- op  out  7  instr_data[6:0].
- funct3  out  3  instr_data[14:12].
- funct7  out  7  instr_data[31:25].
- fetch_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty.
  - imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0.
  - instr_data=32'h0000_0013 (NOP), instr_pc=RESET_PC.
- Space condition: space = (count + (state==WAIT ? 1 : 0)) < FIFO_DEPTH. A push therefore never overflows the FIFO.
- State machine:
  - IDLE: go to REQ when space holds.
  - REQ: imem_req_valid=1, imem_req_addr=fetch_pc. On imem_req_ready, go to WAIT and set fetch_pc+=4, wrapping modulo 2^XLEN.
  - WAIT: on imem_rsp_valid, push {fetch_pc-4, data}, then go to REQ if space holds after the push, else IDLE.
  - DROP: on imem_rsp_valid, discard the data and go to REQ.
- Redirect, applied at the clock edge:
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; misaligned targets are silently aligned.
  - FIFO flushed; count=0.
  - From WAIT, or from REQ with a handshake in the same cycle: go to DROP, because exactly one stale response is owed.
  - From DROP: stay in DROP with the new PC.
  - From IDLE, or from REQ without handshake: go to REQ.
  - A response arriving in the redirect cycle itself is discarded and satisfies the owed response, so the next state is REQ.
  - Redirect beats an instr_ready pop in the same cycle: the head is not considered consumed.
- FIFO:
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - instr_valid = (count != 0).
  - The head fields are stable while instr_valid && !instr_ready.
- Latency and throughput:
  - With memory ready=1 and response one cycle after acceptance: first instr_valid on cycle 4 after reset release (IDLE, REQ, WAIT, push).
  - Steady state: one instruction per 2 cycles (no request pipelining).
- Protocol: imem_req_valid is never withdrawn without a handshake unless a redirect occurs; a redirect changes imem_req_addr on the next cycle.
- Reset asserted mid-transaction: all state cleared immediately. Memory is required to be reset by the same rst, so no stale response survives.

Decomposition:
- Shared package fetch_pkg:
  - State encoding: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DROP=2'd3.
  - NOP_INSTR=32'h0000_0013.
  - Field bit positions for op, funct3 and funct7.
- Sub-module fetch_fifo:
  - Parameterised width/depth, synchronous flush, pointers with wrap bit.
  - Pre-sized for {pc, instr} (XLEN+32 bits).

Test Plan:
- Reset release, ready=1, 1-cycle response memory holding 0x00500093 at address 0 -> imem_req_addr=0 on cycle 2; instr_valid=1 on cycle 4 with instr_pc=0, op=7'h13, funct3=0, funct7=0.
- instr_ready=0 held, FIFO_DEPTH=2 -> exactly 2 requests issued (addr 0, 4), then state IDLE and imem_req_valid=0; raising instr_ready resumes fetching at addr 8.
- redirect_pc=0x103 pulsed while in WAIT for addr 0x8 -> response for 0x8 dropped, FIFO empty, next request addr 0x100, next instr_pc=0x100.
- Redirect in the same cycle as the REQ handshake, then redirect again while in DROP -> exactly one response discarded; fetch proceeds from the second target.
- imem_req_ready held low 5 cycles -> imem_req_valid stays 1 and imem_req_addr stays constant throughout.
- fetch_pc=0xFFFF_FFFC handshake -> next request addr 0x0000_0000; rst pulsed low mid-WAIT -> outputs return to reset values asynchronously.
